// File: rtl/pattern_seq.sv
// pattern_seq: replays a compile-time table of DEPTH patterns, each WIDTH bits,
// over a valid/ready stream. A start pulse launches a one-shot or looping pass.
// An abort pulse returns the block to idle. All outputs are registered.
module pattern_seq #(
  parameter int                       WIDTH    = 2,
  parameter int                       DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0]   PATTERNS = 8'b11_10_00_01,
  parameter int                       IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             loop_en,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  // The index wraps on an explicit compare, so non-power-of-2 depths never
  // reach an unused table slot.
  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            loop_q;

  // Table lookup: entry i occupies bits [i*WIDTH +: WIDTH] of the packed table.
  function automatic logic [WIDTH-1:0] entry(input logic [IDXW-1:0] i);
    entry = PATTERNS[int'(i) * WIDTH +: WIDTH];
  endfunction

  // The index register is also the registered table index seen downstream.
  assign out_idx = idx;

  // Sequencer: handles start/abort and per-entry handshaking, and registers every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      loop_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a same-cycle start, so nothing is launched
          if (start && !abort) begin
            state     <= RUN;
            loop_q    <= loop_en;
            idx       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_data  <= entry('0);
          end
        end
        RUN: begin
          if (abort) begin
            // abort wins over a simultaneous transfer, which is dropped
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
          end else if (out_valid && out_ready) begin
            if (idx == LAST) begin
              if (loop_q) begin
                idx      <= '0;
                out_data <= entry('0);
              end else begin
                state     <= IDLE;
                idx       <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                out_data  <= '0;
                done      <= 1'b1;
              end
            end else begin
              idx      <= idx + IDXW'(1);
              out_data <= entry(idx + IDXW'(1));
            end
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_seq.sv
// tb_pattern_seq: drives three pattern_seq instances from shared stimulus.
// The instances are the default 4x2 table, a 3x3 table, and a single-entry table.
// Each instance is checked every cycle against a transfer-count model, and
// literal expectations on the sequences pin that model down.
module tb_pattern_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, loop_en = 1'b0, abort = 1'b0, out_ready = 1'b0;

  logic       v0, b0, d0, v1, b1, d1, v2, b2, d2;
  logic [1:0] data0, idx0, idx1, data2;
  logic [2:0] data1;
  logic [0:0] idx2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_seq dut0 (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
    .out_ready(out_ready), .out_valid(v0), .out_data(data0), .out_idx(idx0),
    .busy(b0), .done(d0));

  pattern_seq #(.WIDTH(3), .DEPTH(3), .PATTERNS(9'b101_011_110)) dut1 (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
    .out_ready(out_ready), .out_valid(v1), .out_data(data1), .out_idx(idx1),
    .busy(b1), .done(d1));

  pattern_seq #(.WIDTH(2), .DEPTH(1), .PATTERNS(2'b10)) dut2 (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
    .out_ready(out_ready), .out_valid(v2), .out_data(data2), .out_idx(idx2),
    .busy(b2), .done(d2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: each pass is a count of accepted transfers. The visible entry is
  // count mod depth, and a one-shot pass ends after depth transfers.
  int tbl [3][4] = '{'{1, 0, 2, 3}, '{6, 3, 5, 0}, '{2, 0, 0, 0}};
  int depth [3]  = '{4, 3, 1};
  bit m_run [3]  = '{0, 0, 0};
  bit m_loop [3] = '{0, 0, 0};
  bit m_done [3] = '{0, 0, 0};
  int m_cnt [3]  = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_run[k]  <= 1'b0;
        m_loop[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_cnt[k]  <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_run[k]) begin
          if (start && !abort) begin
            m_run[k]  <= 1'b1;
            m_loop[k] <= loop_en;
            m_cnt[k]  <= 0;
          end
        end else if (abort) begin
          m_run[k] <= 1'b0;
        end else if (out_ready) begin
          if (!m_loop[k] && m_cnt[k] + 1 == depth[k]) begin
            m_run[k]  <= 1'b0;
            m_done[k] <= 1'b1;
          end else begin
            m_cnt[k] <= m_cnt[k] + 1;
          end
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model, away from the active edge.
  always @(negedge clk) begin
    int av [3], ab [3], ad [3], adata [3], aidx [3];
    av = '{int'(v0), int'(v1), int'(v2)};
    ab = '{int'(b0), int'(b1), int'(b2)};
    ad = '{int'(d0), int'(d1), int'(d2)};
    adata = '{int'(data0), int'(data1), int'(data2)};
    aidx = '{int'(idx0), int'(idx1), int'(idx2)};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_valid%0d", k), av[k], int'(m_run[k]));
      chk($sformatf("model_busy%0d", k), ab[k], int'(m_run[k]));
      chk($sformatf("model_done%0d", k), ad[k], int'(m_done[k]));
      if (m_run[k]) begin
        chk($sformatf("model_idx%0d", k), aidx[k], m_cnt[k] % depth[k]);
        chk($sformatf("model_data%0d", k), adata[k], tbl[k][m_cnt[k] % depth[k]]);
      end
    end
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int e_os0 [4]   = '{1, 0, 2, 3};
  int e_os1 [3]   = '{6, 3, 5};
  int e_lp0 [10]  = '{1, 0, 2, 3, 1, 0, 2, 3, 1, 0};
  int e_lp1 [10]  = '{6, 3, 5, 6, 3, 5, 6, 3, 5, 6};
  int e_lpi1 [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
  int rdy [7]     = '{1, 0, 0, 1, 0, 1, 1};
  int e_hs0 [7]   = '{1, 0, 0, 0, 2, 2, 3};

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", v0, 0); chk("rst_data", data0, 0); chk("rst_idx", idx0, 0);
    chk("rst_busy", b0, 0);  chk("rst_done", d0, 0);
    rst = 1'b0;

    // One-shot pass, out_ready held high
    @(negedge clk);
    start = 1'b1; loop_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("os_data0_%0d", i), data0, e_os0[i]);
      chk($sformatf("os_idx0_%0d", i), idx0, i);
      chk($sformatf("os_done0_%0d", i), d0, 0);
      if (i < 3) chk($sformatf("os_data1_%0d", i), data1, e_os1[i]);
      if (i == 0) chk("os_data2", data2, 2);
      if (i == 1) chk("os_done2", d2, 1);
      if (i == 3) chk("os_done1", d1, 1);
    end
    @(negedge clk);
    chk("os_done0", d0, 1); chk("os_valid0_end", v0, 0); chk("os_busy0_end", b0, 0);
    @(negedge clk);
    chk("os_done0_clear", d0, 0);

    // Loop mode for ten cycles, then abort
    start = 1'b1; loop_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("lp_data0_%0d", i), data0, e_lp0[i]);
      chk($sformatf("lp_busy0_%0d", i), b0, 1);
      chk($sformatf("lp_done0_%0d", i), d0, 0);
      chk($sformatf("lp_data1_%0d", i), data1, e_lp1[i]);
      chk($sformatf("lp_idx1_%0d", i), idx1, e_lpi1[i]);
      chk($sformatf("lp_data2_%0d", i), data2, 2);
      chk($sformatf("lp_done2_%0d", i), d2, 0);
    end
    abort = 1'b1;
    @(negedge clk);
    chk("lp_abort_valid0", v0, 0); chk("lp_abort_done0", d0, 0);
    // abort together with start while idle: remain idle
    start = 1'b1;
    @(negedge clk);
    chk("idle_abort_start_valid0", v0, 0);
    start = 1'b0; abort = 1'b0;

    // Handshake stalls; start and loop_en toggles in RUN have no effect
    out_ready = 1'b0; loop_en = 1'b0; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = (i == 2) ? 1'b1 : 1'b0;
      if (i == 1) loop_en = 1'b1;
      chk($sformatf("hs_data0_%0d", i), data0, e_hs0[i]);
      chk($sformatf("hs_valid0_%0d", i), v0, 1);
      out_ready = rdy[i][0];
    end
    @(negedge clk);
    chk("hs_done0", d0, 1); chk("hs_valid0_end", v0, 0);
    loop_en = 1'b0;

    // Abort on the same edge as the transfer of idx 2
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("ab_idx0_%0d", i), idx0, i);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid0", v0, 0); chk("ab_done0", d0, 0); chk("ab_done1", d1, 0);
    @(negedge clk);
    chk("ab_done0_late", d0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_restart_data0", data0, 1); chk("ab_restart_idx0", idx0, 0);
    chk("ab_restart_valid0", v0, 1);

    // Asynchronous reset between edges in the middle of a pass
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid0", v0, 0); chk("arst_data0", data0, 0); chk("arst_idx0", idx0, 0);
    chk("arst_busy0", b0, 0);  chk("arst_done0", d0, 0);  chk("arst_valid1", v1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_data0", data0, 1); chk("post_rst_idx0", idx0, 0);
    repeat (6) @(negedge clk);
    chk("post_rst_idle0", v0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
